// File: rtl/lc3b_memory_if.sv
// Request/response bus between the LC-3b datapath (master) and lc3b_memory (slave).
// ERR exists only when MEM_ALIGN_CHECK_EN is defined.
interface lc3b_memory_if;
  logic        MIO_EN;
  logic        R_W;
  logic        DATA_SIZE;
  logic [15:0] MAR;
  logic [15:0] MDR_IN;
  logic [15:0] MEM_OUT;
  logic        R;
`ifdef MEM_ALIGN_CHECK_EN
  logic        ERR;

  modport master (output MIO_EN, R_W, DATA_SIZE, MAR, MDR_IN,
                  input  MEM_OUT, R, ERR);
  modport slave  (input  MIO_EN, R_W, DATA_SIZE, MAR, MDR_IN,
                  output MEM_OUT, R, ERR);
`else
  modport master (output MIO_EN, R_W, DATA_SIZE, MAR, MDR_IN,
                  input  MEM_OUT, R);
  modport slave  (input  MIO_EN, R_W, DATA_SIZE, MAR, MDR_IN,
                  output MEM_OUT, R);
`endif
endinterface

// File: rtl/lc3b_memory.sv
// LC-3b word memory with fixed-latency handshake (R pulses LATENCY edges after sampling).
// Optional misaligned-word detection on ERR under macro MEM_ALIGN_CHECK_EN.
module lc3b_memory #(
  parameter int LATENCY = 5,
  parameter int ADDR_W  = 15
) (
  input logic           clk,
  input logic           rst,
  lc3b_memory_if.slave  bus
);

  localparam int         DEPTH        = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1       = 4'(LATENCY - 1);
  localparam bit         SINGLE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                rst_sync_r;
  logic                r_r;
  logic [15:0]         mem_out_r;
  logic [ADDR_W:0]     req_mar_r;
  logic                req_rw_r;
  logic                req_size_r;
  logic [15:0]         req_mdr_r;

  logic [ADDR_W:0]     acc_addr_s;
  logic                acc_rw_s;
  logic                acc_size_s;
  logic [15:0]         acc_data_s;
  logic [ADDR_W-1:0]   acc_idx_s;
  logic                complete_s;
  logic                misalign_s;
  logic                wr_en_s;
  logic                rd_load_s;
  logic                lane_lo_s;
  logic                lane_hi_s;
  logic [15:0]         rd_word_s;

  logic [15:0]         mem_r [DEPTH];

  // Deassertion is retimed to clk; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 1'b0;
    end else begin
      rst_sync_r <= 1'b1;
    end
  end

  // A single-cycle access completes at its sampling edge, so it must use the live bus.
  always_comb begin
    acc_addr_s = req_mar_r;
    acc_rw_s   = req_rw_r;
    acc_size_s = req_size_r;
    acc_data_s = req_mdr_r;
    if (state_r == IDLE) begin
      acc_addr_s = bus.MAR[ADDR_W:0];
      acc_rw_s   = bus.R_W;
      acc_size_s = bus.DATA_SIZE;
      acc_data_s = bus.MDR_IN;
    end else begin
      acc_addr_s = req_mar_r;
      acc_rw_s   = req_rw_r;
      acc_size_s = req_size_r;
      acc_data_s = req_mdr_r;
    end
  end

  // Completion edge detection.
  always_comb begin
    complete_s = 1'b0;
    case (state_r)
      IDLE:    complete_s = bus.MIO_EN & SINGLE_CYCLE;
      BUSY:    complete_s = bus.MIO_EN & (cnt_r == LAT_M1);
      default: complete_s = 1'b0;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = acc_size_s & acc_addr_s[0];
`else
  assign misalign_s = 1'b0;
`endif

  assign acc_idx_s = acc_addr_s[ADDR_W:1];
  assign rd_word_s = mem_r[acc_idx_s];
  assign wr_en_s   = rst_sync_r & complete_s & acc_rw_s & ~misalign_s;
  assign rd_load_s = complete_s & ~acc_rw_s & ~misalign_s;
  // Byte lanes: word writes both lanes; byte writes pick the lane by MAR[0].
  assign lane_lo_s = acc_size_s | ~acc_addr_s[0];
  assign lane_hi_s = acc_size_s |  acc_addr_s[0];

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (lane_lo_s) begin
        mem_r[acc_idx_s][7:0] <= acc_data_s[7:0];
      end
      if (lane_hi_s) begin
        mem_r[acc_idx_s][15:8] <= acc_data_s[15:8];
      end
    end
  end

  // Request FSM with latency counter and registered response outputs.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      r_r        <= 1'b0;
      mem_out_r  <= 16'h0000;
      req_mar_r  <= '0;
      req_rw_r   <= 1'b0;
      req_size_r <= 1'b0;
      req_mdr_r  <= 16'h0000;
    end else begin
      r_r <= complete_s;
      if (rd_load_s) begin
        mem_out_r <= rd_word_s;
      end
      case (state_r)
        IDLE: begin
          if (bus.MIO_EN) begin
            req_mar_r  <= bus.MAR[ADDR_W:0];
            req_rw_r   <= bus.R_W;
            req_size_r <= bus.DATA_SIZE;
            req_mdr_r  <= bus.MDR_IN;
            cnt_r      <= 4'd1;
            state_r    <= complete_s ? DONE : BUSY;
          end else begin
            cnt_r   <= 4'd0;
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (!bus.MIO_EN) begin
            cnt_r   <= 4'd0;
            state_r <= IDLE;
          end else if (complete_s) begin
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        DONE: begin
          cnt_r   <= 4'd0;
          state_r <= IDLE;
        end
        default: begin
          cnt_r   <= 4'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic err_r;

  // ERR accompanies R only for a misaligned word access.
  always_ff @(posedge clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      err_r <= 1'b0;
    end else begin
      err_r <= complete_s & misalign_s;
    end
  end

  assign bus.ERR = err_r;
`endif

  assign bus.R       = r_r;
  assign bus.MEM_OUT = mem_out_r;

endmodule

// File: tb/tb_lc3b_memory.sv
// Self-checking bench for lc3b_memory: a LATENCY=5 instance (ADDR_W=15) and a
// LATENCY=1 instance (ADDR_W=8, to exercise address aliasing).
module tb_lc3b_memory;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lc3b_memory_if if5 ();
  lc3b_memory_if if1 ();

  lc3b_memory #(.LATENCY(5), .ADDR_W(15)) dut5 (.clk(clk), .rst(rst), .bus(if5));
  lc3b_memory #(.LATENCY(1), .ADDR_W(8))  dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    logic        rw;
    logic        size;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  vec_t        vecs [11];
  logic [15:0] exp_q [$];
  logic [15:0] held [2];
  int          checks = 0;
  int          passed = 0;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic get_r(input bit sel);
    return sel ? if1.R : if5.R;
  endfunction

  function automatic logic [15:0] get_out(input bit sel);
    return sel ? if1.MEM_OUT : if5.MEM_OUT;
  endfunction

  function automatic logic get_err(input bit sel);
`ifdef MEM_ALIGN_CHECK_EN
    return sel ? if1.ERR : if5.ERR;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input bit sel, input logic en, input logic rw, input logic size,
                       input logic [15:0] mar, input logic [15:0] mdr);
    if (sel) begin
      if1.MIO_EN = en; if1.R_W = rw; if1.DATA_SIZE = size; if1.MAR = mar; if1.MDR_IN = mdr;
    end else begin
      if5.MIO_EN = en; if5.R_W = rw; if5.DATA_SIZE = size; if5.MAR = mar; if5.MDR_IN = mdr;
    end
  endtask

  // One full access; called at a negedge, returns at a negedge with MIO_EN low.
  task automatic access(input bit sel, input logic rw, input logic size, input logic [15:0] mar,
                        input logic [15:0] mdr, input logic [15:0] exp_rd, input bit exp_err,
                        input string nm);
    int          lat;
    int          n;
    logic [15:0] e;
    lat = sel ? 1 : 5;
    e = (rw || exp_err) ? held[sel] : exp_rd;
    held[sel] = e;
    exp_q.push_back(e);
    drive(sel, 1'b1, rw, size, mar, mdr);
    @(posedge clk);
    n = 1;
    #1;
    // Post-sample bus changes must not disturb the access in flight.
    drive(sel, 1'b1, ~rw, ~size, ~mar, ~mdr);
    while (!get_r(sel) && n < 20) begin
      @(posedge clk);
      n++;
      #1;
    end
    check({nm, " latency"}, 32'(n), 32'(lat));
    check({nm, " data"}, {16'h0000, get_out(sel)}, {16'h0000, exp_q.pop_front()});
    if (ALIGN_ON) check({nm, " err"}, {31'd0, get_err(sel)}, {31'd0, exp_err});
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check({nm, " r drop"}, {31'd0, get_r(sel)}, 32'd0);
    if (ALIGN_ON) check({nm, " err drop"}, {31'd0, get_err(sel)}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 16'h3000, 16'hBEEF, 16'h0000, "wr3000"};
    vecs[1]  = '{1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, "rd3000"};
    vecs[2]  = '{1'b1, 1'b1, 16'h0040, 16'h1234, 16'h0000, "wr0040"};
    vecs[3]  = '{1'b1, 1'b0, 16'h0041, 16'hAB00, 16'h0000, "wrb0041"};
    vecs[4]  = '{1'b0, 1'b1, 16'h0040, 16'h0000, 16'hAB34, "rd0040a"};
    vecs[5]  = '{1'b1, 1'b0, 16'h0040, 16'h00CD, 16'h0000, "wrb0040"};
    vecs[6]  = '{1'b0, 1'b0, 16'h0041, 16'h0000, 16'hABCD, "rdb0041"};
    vecs[7]  = '{1'b1, 1'b1, 16'h7FFE, 16'h0F0F, 16'h0000, "wr7ffe"};
    vecs[8]  = '{1'b0, 1'b0, 16'h7FFF, 16'h0000, 16'h0F0F, "rdb7fff"};
    vecs[9]  = '{1'b1, 1'b0, 16'h7FFF, 16'h1200, 16'h0000, "wrb7fff"};
    vecs[10] = '{1'b0, 1'b1, 16'h7FFE, 16'h0000, 16'h120F, "rd7ffe"};
    held[0] = 16'h0000;
    held[1] = 16'h0000;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset r5", {31'd0, if5.R}, 32'd0);
    check("reset out5", {16'h0000, if5.MEM_OUT}, 32'd0);
    check("reset r1", {31'd0, if1.R}, 32'd0);
    check("reset out1", {16'h0000, if1.MEM_OUT}, 32'd0);
    if (ALIGN_ON) check("reset err5", {31'd0, get_err(1'b0)}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      access(1'b0, vecs[i].rw, vecs[i].size, vecs[i].mar, vecs[i].mdr, vecs[i].exp, 1'b0, vecs[i].nm);

    // Abort: request withdrawn after the third edge of a write.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h5555);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("abort r busy", {31'd0, if5.R}, 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int k = 4; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("abort r idle", {31'd0, if5.R}, 32'd0);
    end
    check("abort out held", {16'h0000, if5.MEM_OUT}, 32'h0000120F);
    @(negedge clk);
    access(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'hABCD, 1'b0, "rd after abort");

    // Reset in the middle of a write.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h3000, 16'h7777);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst r", {31'd0, if5.R}, 32'd0);
    check("midrst out", {16'h0000, if5.MEM_OUT}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    held[0] = 16'h0000;
    held[1] = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    access(1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, 1'b0, "rd after rst");

    // Misaligned word write: suppressed with ERR, or a plain word write otherwise.
    access(1'b0, 1'b1, 1'b1, 16'h0041, 16'h9999, 16'h0000, ALIGN_ON, "misaligned wr");
    access(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000, ALIGN_ON ? 16'hABCD : 16'h9999, 1'b0, "rd misaligned");

    // LATENCY=1 instance with aliasing modulo 512 bytes.
    access(1'b1, 1'b1, 1'b1, 16'h0040, 16'h1111, 16'h0000, 1'b0, "l1 wr0040");
    access(1'b1, 1'b1, 1'b1, 16'h0242, 16'h2222, 16'h0000, 1'b0, "l1 wr0242");
    access(1'b1, 1'b0, 1'b1, 16'h0240, 16'h0000, 16'h1111, 1'b0, "l1 alias rd");

    // Back-to-back reads with MIO_EN held: R on edges 1 and 3.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000);
    @(posedge clk);
    #1;
    check("b2b r e1", {31'd0, if1.R}, 32'd1);
    check("b2b out e1", {16'h0000, if1.MEM_OUT}, 32'h00001111);
    @(negedge clk);
    if1.MAR = 16'h0042;
    @(posedge clk);
    #1;
    check("b2b r e2", {31'd0, if1.R}, 32'd0);
    @(posedge clk);
    #1;
    check("b2b r e3", {31'd0, if1.R}, 32'd1);
    check("b2b out e3", {16'h0000, if1.MEM_OUT}, 32'h00002222);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check("b2b r e4", {31'd0, if1.R}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lc3b_memory.md
LC3B_MEMORY -- requirements
Module: lc3b_memory

Interface
REQ-001 Parameter LATENCY, default 5: edges from request sample to R assertion; legal range 1..15.
REQ-002 Parameter ADDR_W, default 15: word-address bits; the array holds 2^ADDR_W 16-bit words.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 Port MIO_EN, input, 1: memory request, held high by the datapath until R is seen.
REQ-006 Port R_W, input, 1: access direction, 0 = read, 1 = write.
REQ-007 Port DATA_SIZE, input, 1: access size, 0 = byte, 1 = word.
REQ-008 Port MAR, input, 16: byte address.
REQ-009 Port MDR_IN, input, 16: write data from the datapath MDR.
REQ-010 Port MEM_OUT, output, 16: read data, i.e. the aligned word.
REQ-011 Port R, output, 1: access-complete, one-cycle pulse.
REQ-012 Port ERR, output, 1: misaligned-access flag; present only under MEM_ALIGN_CHECK_EN.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE, with a 4-bit latency counter CNT.
REQ-014 IDLE: MIO_EN sampled high SHALL latch MAR, R_W, DATA_SIZE and MDR_IN into request registers, set CNT=1, and go to BUSY (LATENCY>1) or complete at that same edge (LATENCY=1).
REQ-015 BUSY, MIO_EN high, CNT<LATENCY-1: SHALL increment CNT.
REQ-016 BUSY, MIO_EN high, CNT=LATENCY-1: SHALL complete at this edge.
REQ-017 Completing edge SHALL set R=1, perform the access using latched values, and go to DONE; R therefore rises exactly LATENCY edges after the sampling edge.
REQ-018 Read SHALL load MEM_OUT with word mem[MAR[ADDR_W:1]] at the completing edge, for both byte and word sizes; byte-lane selection belongs to the datapath.
REQ-019 MEM_OUT SHALL hold its value until the next read completes; writes do not change MEM_OUT.
REQ-020 Word write SHALL store MDR_IN[15:0] to mem[MAR[ADDR_W:1]], ignoring MAR[0].
REQ-021 Byte write with MAR[0]=0 SHALL store MDR_IN[7:0] to bits 7:0 only.
REQ-022 Byte write with MAR[0]=1 SHALL store MDR_IN[15:8] to bits 15:8 only.
REQ-023 MAR bits above ADDR_W SHALL be ignored, so addresses alias modulo 2^(ADDR_W+1) bytes.
REQ-024 DONE SHALL last exactly one cycle with R=1, SHALL ignore MIO_EN, and SHALL then go to IDLE with R=0.
REQ-025 A request still high after DONE SHALL be sampled as a new access in IDLE.
REQ-026 Abort: MIO_EN sampled low in BUSY SHALL return to IDLE with no array write, no R pulse and MEM_OUT unchanged.
REQ-027 Changes to MAR, R_W, DATA_SIZE or MDR_IN after the sampling edge SHALL have no effect on the access in flight.

Reset
REQ-028 rst low SHALL asynchronously force state IDLE, CNT=0, R=0, MEM_OUT=16'h0000 and ERR=0.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 Reset asserted during BUSY or DONE SHALL cancel the access with no write.
REQ-031 Release SHALL be synchronised to clk; the first request can be sampled at the second rising edge after rst rises.

Configuration
REQ-032 With macro MEM_ALIGN_CHECK_EN defined, a word access with MAR[0]=1 SHALL still run the full LATENCY and pulse R, SHALL suppress any array write, SHALL leave MEM_OUT unchanged, and SHALL assert ERR for the R cycle only.
REQ-033 With MEM_ALIGN_CHECK_EN undefined, port ERR SHALL be absent and a misaligned word access SHALL proceed as in REQ-018/REQ-020.

Verification
REQ-034 Word write MAR=16'h3000, MDR_IN=16'hBEEF, LATENCY=5, then word read of 16'h3000 -> R high exactly 5 edges after each sample, MEM_OUT=16'hBEEF.
REQ-035 Word write 16'h1234 to 16'h0040, byte write MAR=16'h0041 with MDR_IN=16'hAB00, then read -> MEM_OUT=16'hAB34.
REQ-036 MIO_EN dropped after edge 3 of a write of 16'h5555 to 16'h0040 -> no R pulse, following read returns the prior 16'hAB34.
REQ-037 rst pulsed low mid-BUSY of a write -> R=0 and MEM_OUT=0 immediately, array word unchanged.
REQ-038 MEM_ALIGN_CHECK_EN defined, word write to 16'h0041 -> R and ERR high together for one cycle, word 16'h0040 unchanged.
REQ-039 LATENCY=1, MIO_EN held high over two back-to-back reads -> R pulses on edges 1 and 3 and MEM_OUT updates on each pulse.
